// File: rtl/mc_pkg.sv
// Shared constants and control-vector type for the multi-cycle CPU main control unit.
// Optional BNE support is selected by MC_CTRL_BNE_EN in mc_ctrl.sv / mc_ctrl_outdec.sv.
package mc_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned ST_W  = 4;

    typedef logic [OPC_W-1:0] opcode_t;
    typedef logic [ST_W-1:0]  state_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_BNE   = 6'b000101;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;

    localparam state_t ST_FETCH  = 4'd0;
    localparam state_t ST_DECODE = 4'd1;
    localparam state_t ST_MEMADR = 4'd2;
    localparam state_t ST_MEMRD  = 4'd3;
    localparam state_t ST_MEMWB  = 4'd4;
    localparam state_t ST_MEMWR  = 4'd5;
    localparam state_t ST_REX    = 4'd6;
    localparam state_t ST_RWB    = 4'd7;
    localparam state_t ST_BEQ    = 4'd8;
    localparam state_t ST_JMP    = 4'd9;
    localparam state_t ST_IEX    = 4'd10;
    localparam state_t ST_IWB    = 4'd11;
    localparam state_t ST_BNE    = 4'd12;
    localparam state_t ST_IDLE   = 4'd15;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the main control unit (master) and the datapath (slave).
interface mc_ctrl_if
    import mc_pkg::*;
#(
    parameter int unsigned STATE_W = 4
);

    opcode_t            opcode;
    logic               zero;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               pc_ce;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSource;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero,
        output PCWrite, PCWriteCond, pc_ce, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state
    );

    modport slave (
        output opcode, zero,
        input  PCWrite, PCWriteCond, pc_ce, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state
    );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: maps the control FSM state to the datapath control vector.
// State 12 (BNE) drives outputs only when MC_CTRL_BNE_EN is defined.
module mc_ctrl_outdec
    import mc_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.pc_write  = 1'b1;
            end
            // Branch target is precomputed into ALUOut while the opcode decodes
            ST_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH2;
            ST_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            ST_REX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            ST_BEQ: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
`ifdef MC_CTRL_BNE_EN
            ST_BNE: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
`endif
            ST_JMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            ST_IEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            ST_IWB: o_ctrl.reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU main control FSM: sequences fetch/decode/execute/memory/write-back.
// Define MC_CTRL_BNE_EN to decode opcode 000101 as BNE (branch on ~zero).
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   bus
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_RTYPE:     w_next = ST_REX;
                    OP_BEQ:       w_next = ST_BEQ;
                    OP_J:         w_next = ST_JMP;
                    OP_ADDI:      w_next = ST_IEX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       w_next = ST_BNE;
`endif
                    default:      w_next = ST_FETCH;
                endcase
            end
            // IR is stable here, so the opcode is re-read to split lw from sw
            ST_MEMADR: w_next = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  w_next = ST_MEMWB;
            ST_REX:    w_next = ST_RWB;
            ST_IEX:    w_next = ST_IWB;
            default:   w_next = ST_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    always_comb begin
        w_taken = bus.zero;
`ifdef MC_CTRL_BNE_EN
        if (r_state == ST_BNE) w_taken = ~bus.zero;
`endif
        bus.PCWrite     = w_ctrl.pc_write;
        bus.PCWriteCond = w_ctrl.pc_write_cond;
        bus.pc_ce       = w_ctrl.pc_write | (w_ctrl.pc_write_cond & w_taken);
        bus.IorD        = w_ctrl.iord;
        bus.MemRead     = w_ctrl.mem_read;
        bus.MemWrite    = w_ctrl.mem_write;
        bus.IRWrite     = w_ctrl.ir_write;
        bus.MemtoReg    = w_ctrl.mem_to_reg;
        bus.RegDst      = w_ctrl.reg_dst;
        bus.RegWrite    = w_ctrl.reg_write;
        bus.ALUSrcA     = w_ctrl.alu_src_a;
        bus.ALUSrcB     = w_ctrl.alu_src_b;
        bus.ALUOp       = w_ctrl.alu_op;
        bus.PCSource    = w_ctrl.pc_source;
        bus.state       = STATE_W'(r_state);
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector bench for mc_ctrl: state sequences and control strobes per instruction class.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.STATE_W(4)) bus ();

    mc_ctrl #(.STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic test_reset();
        logic [16:0] v;
        bus.opcode = OP_RTYPE;
        bus.zero   = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.state !== 4'd15) begin
            n_err++; $display("FAIL reset_state got %0d want 15", bus.state);
        end
        v = {bus.PCWrite, bus.PCWriteCond, bus.pc_ce, bus.IorD, bus.MemRead, bus.MemWrite,
             bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
             bus.ALUSrcB, bus.ALUOp, bus.PCSource};
        n_vec++;
        if (v !== 17'd0) begin
            n_err++; $display("FAIL reset_outputs got %h want 0", v);
        end
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (bus.state !== 4'd15) begin
            n_err++; $display("FAIL reset_hold got %0d want 15", bus.state);
        end
        @(negedge clk);
        n_vec++;
        if (bus.state !== 4'd0) begin
            n_err++; $display("FAIL reset_release_state got %0d want 0", bus.state);
        end
        v = {12'd0, bus.MemRead, bus.IRWrite, bus.PCWrite, bus.pc_ce, bus.ALUSrcB == 2'b01};
        n_vec++;
        if (v !== 17'h1F) begin
            n_err++; $display("FAIL fetch_strobes got %h want 1f", v);
        end
    endtask

    task automatic test_lw();
        logic [3:0] seq [5];
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        bus.opcode = OP_LW;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.state !== seq[i]) begin
                n_err++; $display("FAIL lw_state[%0d] got %0d want %0d", i, bus.state, seq[i]);
            end
            if (seq[i] == 4'd1) begin
                n_vec++;
                if (bus.ALUSrcB !== 2'b11 || bus.pc_ce !== 1'b0) begin
                    n_err++; $display("FAIL decode_outs got srcb=%b pc_ce=%b want 11/0", bus.ALUSrcB, bus.pc_ce);
                end
            end
            if (seq[i] == 4'd2) begin
                n_vec++;
                if (bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b10) begin
                    n_err++; $display("FAIL memadr_outs got a=%b b=%b want 1/10", bus.ALUSrcA, bus.ALUSrcB);
                end
            end
            if (seq[i] == 4'd3) begin
                n_vec++;
                if ({bus.IorD, bus.MemRead, bus.RegWrite} !== 3'b110) begin
                    n_err++; $display("FAIL memrd_outs got %b want 110", {bus.IorD, bus.MemRead, bus.RegWrite});
                end
            end
            if (seq[i] == 4'd4) begin
                n_vec++;
                if ({bus.RegWrite, bus.MemtoReg, bus.RegDst} !== 3'b110) begin
                    n_err++; $display("FAIL memwb_outs got %b want 110", {bus.RegWrite, bus.MemtoReg, bus.RegDst});
                end
            end
        end
    endtask

    task automatic test_sw();
        logic [3:0] seq [4];
        seq = '{4'd1, 4'd2, 4'd5, 4'd0};
        bus.opcode = OP_SW;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.state !== seq[i]) begin
                n_err++; $display("FAIL sw_state[%0d] got %0d want %0d", i, bus.state, seq[i]);
            end
            n_vec++;
            if (bus.MemWrite !== (seq[i] == 4'd5)) begin
                n_err++; $display("FAIL sw_memwrite[%0d] got %b want %b", i, bus.MemWrite, seq[i] == 4'd5);
            end
        end
    endtask

    task automatic test_rtype();
        logic [3:0] seq [4];
        seq = '{4'd1, 4'd6, 4'd7, 4'd0};
        bus.opcode = OP_RTYPE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.state !== seq[i]) begin
                n_err++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, bus.state, seq[i]);
            end
            if (seq[i] == 4'd6) begin
                n_vec++;
                if (bus.ALUOp !== 2'b10 || bus.ALUSrcA !== 1'b1) begin
                    n_err++; $display("FAIL rex_outs got op=%b a=%b want 10/1", bus.ALUOp, bus.ALUSrcA);
                end
            end
            if (seq[i] == 4'd7) begin
                n_vec++;
                if ({bus.RegWrite, bus.RegDst} !== 2'b11) begin
                    n_err++; $display("FAIL rwb_outs got %b want 11", {bus.RegWrite, bus.RegDst});
                end
            end
        end
    endtask

    task automatic test_addi();
        logic [3:0] seq [4];
        seq = '{4'd1, 4'd10, 4'd11, 4'd0};
        bus.opcode = OP_ADDI;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.state !== seq[i]) begin
                n_err++; $display("FAIL addi_state[%0d] got %0d want %0d", i, bus.state, seq[i]);
            end
            if (seq[i] == 4'd11) begin
                n_vec++;
                if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b100) begin
                    n_err++; $display("FAIL iwb_outs got %b want 100", {bus.RegWrite, bus.RegDst, bus.MemtoReg});
                end
            end
        end
    endtask

    task automatic test_beq(input logic z);
        bus.opcode = OP_BEQ;
        bus.zero   = z;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.state !== 4'd8) begin
            n_err++; $display("FAIL beq_state z=%b got %0d want 8", z, bus.state);
        end
        n_vec++;
        if (bus.pc_ce !== z || bus.PCSource !== 2'b01 || bus.PCWriteCond !== 1'b1 || bus.ALUOp !== 2'b01) begin
            n_err++; $display("FAIL beq_outs z=%b got pc_ce=%b src=%b cond=%b op=%b want %b/01/1/01",
                              z, bus.pc_ce, bus.PCSource, bus.PCWriteCond, bus.ALUOp, z);
        end
        @(negedge clk);
        n_vec++;
        if (bus.state !== 4'd0) begin
            n_err++; $display("FAIL beq_return got %0d want 0", bus.state);
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jmp();
        bus.opcode = OP_J;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.state !== 4'd9 || bus.pc_ce !== 1'b1 || bus.PCSource !== 2'b10) begin
            n_err++; $display("FAIL jmp_outs got st=%0d pc_ce=%b src=%b want 9/1/10", bus.state, bus.pc_ce, bus.PCSource);
        end
        @(negedge clk);
        n_vec++;
        if (bus.state !== 4'd0) begin
            n_err++; $display("FAIL jmp_return got %0d want 0", bus.state);
        end
    endtask

    task automatic test_illegal();
        bus.opcode = 6'b111111;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.state !== ((i == 0) ? 4'd1 : 4'd0)) begin
                n_err++; $display("FAIL illegal_state[%0d] got %0d want %0d", i, bus.state, (i == 0) ? 1 : 0);
            end
            n_vec++;
            if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin
                n_err++; $display("FAIL illegal_side_effect[%0d] got rw=%b mw=%b want 0/0", i, bus.RegWrite, bus.MemWrite);
            end
        end
    endtask

    task automatic test_bne();
        bus.opcode = OP_BNE;
        bus.zero   = 1'b0;
        @(negedge clk);
        @(negedge clk);
`ifdef MC_CTRL_BNE_EN
        n_vec++;
        if (bus.state !== 4'd12 || bus.pc_ce !== 1'b1 || bus.PCSource !== 2'b01) begin
            n_err++; $display("FAIL bne_taken got st=%0d pc_ce=%b src=%b want 12/1/01", bus.state, bus.pc_ce, bus.PCSource);
        end
        bus.zero = 1'b1;
        #1;
        n_vec++;
        if (bus.pc_ce !== 1'b0) begin
            n_err++; $display("FAIL bne_not_taken got pc_ce=%b want 0", bus.pc_ce);
        end
        bus.zero = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.state !== 4'd0) begin
            n_err++; $display("FAIL bne_return got %0d want 0", bus.state);
        end
`else
        n_vec++;
        if (bus.state !== 4'd0 || bus.pc_ce !== 1'b1) begin
            n_err++; $display("FAIL bne_illegal got st=%0d pc_ce=%b want 0/1", bus.state, bus.pc_ce);
        end
`endif
    endtask

    task automatic test_reset_mid_lw();
        bus.opcode = OP_LW;
        for (int i = 1; i <= 3; i++) @(negedge clk);
        n_vec++;
        if (bus.state !== 4'd3 || bus.MemRead !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre got st=%0d mr=%b want 3/1", bus.state, bus.MemRead);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.state !== 4'd15 || bus.MemRead !== 1'b0) begin
            n_err++; $display("FAIL midrst_abort got st=%0d mr=%b want 15/0", bus.state, bus.MemRead);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.RegWrite !== 1'b0 || bus.state !== 4'd15) begin
                n_err++; $display("FAIL midrst_hold[%0d] got st=%0d rw=%b want 15/0", i, bus.state, bus.RegWrite);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.state !== 4'd0 || bus.RegWrite !== 1'b0) begin
            n_err++; $display("FAIL midrst_restart got st=%0d rw=%b want 0/0", bus.state, bus.RegWrite);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_addi();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jmp();
        test_illegal();
        test_bne();
        test_reset_mid_lw();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
